// File: rtl/result_accum_buffer.sv
// result_accum_buffer: CHANNELS x LAYER_SIZE signed partial-sum store for one
// convolution layer. Supports single-cycle store/accumulate, per-channel bias
// and ReLU sweeps, and a valid/ready readout stream of one channel.
// Build option: define ACC_SAT_EN to saturate accumulation; otherwise it wraps.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepts one command per cycle (bias_init > relu > readout > store)
// BIAS   | writes latched bias into entries 0..LAYER_SIZE-1 of latched channel
// RELU   | clamps negative entries of latched channel to zero, one per cycle
// READ   | streams latched channel, advancing on rd_valid & rd_ready
module result_accum_buffer #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int CHANNELS   = 8,
  parameter int LAYER_SIZE = 64,
  parameter int CH_W       = $clog2(CHANNELS),
  parameter int ADDR_W     = $clog2(LAYER_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store,
  input  logic              accumulate,
  input  logic              bias_init,
  input  logic              relu,
  input  logic              readout,
  input  logic [CH_W-1:0]   out_c,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ACC_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIAS = 2'd1,
    S_RELU = 2'd2,
    S_READ = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAYER_SIZE - 1);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   bias_q, bias_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    mem_q [CHANNELS][LAYER_SIZE];

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ACC_W-1:0]    wr_data;

  logic                ch_ok, addr_ok;
  logic [ACC_W-1:0]    store_entry, sweep_entry;
  logic [ACC_W-1:0]    value_ext, bias_ext, relu_val, acc_result;

  // Out-of-range channel/address checks done one bit wider so they stay
  // meaningful when CHANNELS or LAYER_SIZE is not a power of two.
  assign ch_ok   = {1'b0, out_c} < (CH_W + 1)'(CHANNELS);
  assign addr_ok = {1'b0, addr} < (ADDR_W + 1)'(LAYER_SIZE);

  assign store_entry = mem_q[out_c][addr];
  assign sweep_entry = mem_q[ch_q][idx_q];
  assign value_ext   = ACC_W'($signed(value));
  assign bias_ext    = ACC_W'($signed(bias_q));
  assign relu_val    = sweep_entry[ACC_W-1] ? '0 : sweep_entry;

`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {store_entry[ACC_W-1], store_entry} + (ACC_W + 1)'($signed(value));

  // Clamp when the extra sign bit disagrees with the top result bit.
  always_comb begin
    acc_result = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_result = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_result = store_entry + value_ext;
`endif

  // Next-state, sweep/readout index and the single memory write port.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bias_d  = bias_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = ch_q;
    wr_addr = idx_q;
    wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ch_ok) begin
          if (bias_init) begin
            state_d = S_BIAS;
            ch_d    = out_c;
            bias_d  = bias;
            idx_d   = '0;
          end else if (relu) begin
            state_d = S_RELU;
            ch_d    = out_c;
            idx_d   = '0;
          end else if (readout) begin
            state_d = S_READ;
            ch_d    = out_c;
            idx_d   = '0;
          end else if (store && addr_ok) begin
            wr_en   = 1'b1;
            wr_ch   = out_c;
            wr_addr = addr;
            wr_data = accumulate ? acc_result : value_ext;
          end
        end
      end
      S_BIAS, S_RELU: begin
        wr_en   = 1'b1;
        wr_data = (state_q == S_BIAS) ? bias_ext : relu_val;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_READ: begin
        if (rd_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset aborts any sweep or readout without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      bias_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      bias_q  <= bias_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Entry storage: cleared on reset, one write per cycle otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int a = 0; a < LAYER_SIZE; a++) begin
          mem_q[c][a] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_q[wr_ch][wr_addr] <= wr_data;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign rd_valid = (state_q == S_READ);
  assign rd_addr  = rd_valid ? idx_q : '0;
  assign rd_data  = rd_valid ? sweep_entry : '0;
  assign rd_last  = rd_valid && (idx_q == LAST_IDX);
  assign done     = done_q;

endmodule

// File: tb/tb_result_accum_buffer.sv
// Scoreboard bench for result_accum_buffer: the driver updates a plain-array
// model and queues expected readout beats; a negedge monitor pops and compares.
module tb_result_accum_buffer;
  localparam int DATA_W = 8;
  localparam int ACC_W = 16;
  localparam int CHANNELS = 8;
  localparam int LAYER_SIZE = 64;
  localparam int CH_W = 3;
  localparam int ADDR_W = 6;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst, store, accumulate, bias_init, relu, readout;
  logic [CH_W-1:0] out_c;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] value, bias;
  logic busy, rd_valid, rd_last, done;
  logic rd_ready = 1'b1;
  logic [ACC_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;

  always #5 clk = ~clk;

  result_accum_buffer dut (
    .clk(clk), .rst(rst), .store(store), .accumulate(accumulate),
    .bias_init(bias_init), .relu(relu), .readout(readout), .out_c(out_c),
    .addr(addr), .value(value), .bias(bias), .busy(busy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr), .rd_last(rd_last),
    .done(done)
  );

  typedef struct {
    int     a;
    longint d;
    bit     l;
  } rd_item_t;

  rd_item_t exp_q[$];
  longint model[CHANNELS][LAYER_SIZE];
  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;
  int ready_cnt = 0;
  int done_cnt = 0;

  task automatic check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint acc_fn(longint a, longint v);
    longint s;
    s = a + v;
`ifdef ACC_SAT_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`else
    s = ((s - MINV) & ((longint'(1) <<< ACC_W) - 1)) + MINV;
`endif
    return s;
  endfunction

  // Consumer ready pattern: always, 1-0-0-1 repeating, or random.
  always @(posedge clk) begin
    #1;
    ready_cnt++;
    case (ready_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = ((ready_cnt % 4) == 0) || ((ready_cnt % 4) == 3);
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares each transfer against the scoreboard and checks hold while stalled.
  logic prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_data", rd_data, prev_data);
        check("stall_addr", rd_addr, prev_addr);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_beat", exp_q.size(), 1);
        end else begin
          rd_item_t it;
          it = exp_q.pop_front();
          check("rd_addr", rd_addr, it.a);
          check("rd_data", longint'($signed(rd_data)), it.d);
          check("rd_last", rd_last, it.l);
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_addr = rd_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(int ch, int a, int v, bit acc);
    store = 1'b1; accumulate = acc; out_c = CH_W'(ch); addr = ADDR_W'(a); value = DATA_W'(v);
    model[ch][a] = acc ? acc_fn(model[ch][a], v) : longint'(v);
    cyc();
    store = 1'b0; accumulate = 1'b0;
  endtask

  // kind 0 = bias, 1 = relu; extra raises every lower-priority command too.
  task automatic do_sweep(int kind, int ch, int b, bit extra);
    int n;
    out_c = CH_W'(ch); bias = DATA_W'(b);
    bias_init = (kind == 0);
    relu = (kind == 1) || extra;
    readout = extra; store = extra; accumulate = 1'b0;
    addr = '0; value = DATA_W'(99);
    for (int a = 0; a < LAYER_SIZE; a++) begin
      if (kind == 0) model[ch][a] = b;
      else if (model[ch][a] < 0) model[ch][a] = 0;
    end
    cyc();
    bias_init = 1'b0; relu = 1'b0; readout = 1'b0; store = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      cyc();
    end
    check("sweep_busy_cycles", n, LAYER_SIZE);
    check("sweep_done", done, 1);
    cyc();
    check("sweep_done_pulse_len", done, 0);
  endtask

  task automatic do_read(int ch, bit inject);
    int n;
    for (int a = 0; a < LAYER_SIZE; a++) begin
      rd_item_t it;
      it.a = a; it.d = model[ch][a]; it.l = (a == LAYER_SIZE - 1);
      exp_q.push_back(it);
    end
    out_c = CH_W'(ch); readout = 1'b1;
    cyc();
    readout = 1'b0;
    check("read_valid_start", rd_valid, 1);
    n = 0;
    while (!done && n < 5000) begin
      if (inject && n == 3) begin
        store = 1'b1; relu = 1'b1; accumulate = 1'b0; out_c = CH_W'(ch);
        addr = ADDR_W'(7); value = DATA_W'(50);
      end
      if (n == 8) begin store = 1'b0; relu = 1'b0; end
      n++;
      cyc();
    end
    store = 1'b0; relu = 1'b0;
    check("read_done", done, 1);
    check("read_valid_at_done", rd_valid, 0);
    check("read_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    cyc();
    check("read_done_pulse_len", done, 0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; store = 0; accumulate = 0; bias_init = 0; relu = 0; readout = 0;
    out_c = '0; addr = '0; value = '0; bias = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int a = 0; a < LAYER_SIZE; a++) model[c][a] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_done", done, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_addr", rd_addr, 0);
    rst = 1'b0;
    cyc();

    do_read(0, 0);
    do_sweep(0, 1, 5, 0);
    do_read(1, 0);
    do_read(0, 0);

    do_store(1, 4, 10, 1);
    do_store(1, 5, -8, 0);
    do_sweep(1, 1, 0, 0);
    do_read(1, 0);

    for (int i = 0; i < 260; i++) do_store(2, 0, 127, 1);
    do_read(2, 0);
`ifdef ACC_SAT_EN
    check("sat_model_addr0", model[2][0], 32767);
`else
    check("wrap_model_addr0", model[2][0], -32516);
`endif

    ready_mode = 1;
    do_read(1, 1);
    ready_mode = 0;
    do_read(1, 0);

    do_sweep(0, 4, -3, 1);
    do_read(4, 0);
    do_store(4, 9, 100, 1);
    do_sweep(1, 4, 0, 1);
    do_read(4, 0);

    out_c = CH_W'(3); bias = DATA_W'(7); bias_init = 1'b1;
    cyc();
    bias_init = 1'b0;
    repeat (30) cyc();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_data", rd_data, 0);
    for (int c = 0; c < CHANNELS; c++)
      for (int a = 0; a < LAYER_SIZE; a++) model[c][a] = 0;
    dc = done_cnt;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("abort_no_done", done_cnt, dc);
    check("abort_idle", busy, 0);
    do_read(3, 0);
    do_read(1, 0);
    do_sweep(0, 3, -2, 0);
    do_read(3, 0);

    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      int ch;
      ch = int'($urandom_range(0, CHANNELS - 1));
      for (int i = 0; i < 40; i++) begin
        do_store((i % 3 == 0) ? ch : int'($urandom_range(0, CHANNELS - 1)),
                 int'($urandom_range(0, LAYER_SIZE - 1)),
                 int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) do_sweep(0, ch, int'($urandom_range(0, 255)) - 128, 0);
      if ($urandom_range(0, 1) == 1) do_sweep(1, ch, 0, 0);
      do_read(ch, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
